// File: rtl/pingpong_buffer_if.sv
// pingpong_buffer_if: DMA port, JTAG port and swap/fill control signals of
// the dual-bank ping-pong buffer. The slave modport is the buffer itself,
// the master modport is the surrounding JTAG/DMA logic.
interface pingpong_buffer_if #(
  parameter int AddrWidth = 9
);
  // DMA side
  logic [AddrWidth-1:0] pp_address;
  logic [31:0]          pp_dataIn;
  logic                 pp_writeEnable;
  logic [31:0]          pp_dataOut;
  // JTAG side
  logic [AddrWidth-1:0] jtag_address;
  logic [31:0]          jtag_dataIn;
  logic                 jtag_writeEnable;
  logic [31:0]          jtag_dataOut;
  // Swap control and fill reporting
  logic                 swap_request;
  logic                 dma_busy;
  logic                 jtag_clear;
  logic                 bank_select;
  logic                 swap_pending;
  logic                 swap_done;
  logic [AddrWidth:0]   jtag_fill;
  logic [AddrWidth:0]   dma_fill;

  modport master (
    output pp_address, pp_dataIn, pp_writeEnable,
    output jtag_address, jtag_dataIn, jtag_writeEnable,
    output swap_request, dma_busy, jtag_clear,
    input  pp_dataOut, jtag_dataOut,
    input  bank_select, swap_pending, swap_done, jtag_fill, dma_fill
  );

  modport slave (
    input  pp_address, pp_dataIn, pp_writeEnable,
    input  jtag_address, jtag_dataIn, jtag_writeEnable,
    input  swap_request, dma_busy, jtag_clear,
    output pp_dataOut, jtag_dataOut,
    output bank_select, swap_pending, swap_done, jtag_fill, dma_fill
  );
endinterface

// File: rtl/pingpong_buffer.sv
// pingpong_buffer: two 2^AddrWidth x 32 banks. The DMA owns bank[bank_select]
// (combinational read), the JTAG side owns the other bank (registered read).
// A three-state FSM exchanges the banks on request once the DMA is idle.
// Optional feature macro: PINGPONG_FILL_COUNT_EN builds the per-bank
// high-water counters; without it both fill outputs read as a full bank.
module pingpong_buffer #(
  parameter int AddrWidth = 9
) (
  input  logic              clock,
  input  logic              n_reset,
  pingpong_buffer_if.slave  bus
);

  localparam int Depth = 1 << AddrWidth;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PENDING,
    S_SWAP
  } state_e;

  state_e               state_q, state_d;
  logic                 bank_select_q;
  logic                 swap_done_q;
  logic                 jtag_bank;
  logic [31:0]          jtag_data_q;
  logic [31:0]          mem [2][Depth];

  // Per-bank write port, steered from whichever side owns that bank
  logic                 wr_en   [2];
  logic [AddrWidth-1:0] wr_addr [2];
  logic [31:0]          wr_data [2];

  assign jtag_bank = ~bank_select_q;

  // Route each side's write to the bank it currently owns
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      if (1'(b) == bank_select_q) begin
        wr_en[b]   = bus.pp_writeEnable;
        wr_addr[b] = bus.pp_address;
        wr_data[b] = bus.pp_dataIn;
      end else begin
        wr_en[b]   = bus.jtag_writeEnable;
        wr_addr[b] = bus.jtag_address;
        wr_data[b] = bus.jtag_dataIn;
      end
    end
  end

  // Bank storage writes; the two sides never target the same bank
  // NOTE: storage has no reset; clearing RAM contents costs a reset tree over
  // every word and the consumers only ever read words that were written.
  always_ff @(posedge clock) begin
    for (int b = 0; b < 2; b++) begin
      if (wr_en[b]) mem[b][wr_addr[b]] <= wr_data[b];
    end
  end

  // DMA read is combinational from the DMA-owned bank
  assign bus.pp_dataOut = mem[bank_select_q][bus.pp_address];

  // JTAG read is registered; a same-cycle write returns the old word
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) jtag_data_q <= '0;
    else          jtag_data_q <= mem[jtag_bank][bus.jtag_address];
  end

  // Swap FSM state register
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Swap FSM next state; requests outside S_IDLE are dropped, not queued
  // NOTE: state_d takes a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (bus.swap_request) state_d = S_PENDING;
      S_PENDING: if (!bus.dma_busy)    state_d = S_SWAP;
      S_SWAP:                          state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  // Bank toggle and swap_done pulse on the edge leaving S_SWAP
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      bank_select_q <= 1'b0;
      swap_done_q   <= 1'b0;
    end else begin
      if (state_q == S_SWAP) bank_select_q <= ~bank_select_q;
      swap_done_q <= (state_q == S_SWAP);
    end
  end

  assign bus.bank_select  = bank_select_q;
  assign bus.swap_pending = (state_q != S_IDLE);
  assign bus.swap_done    = swap_done_q;
  assign bus.jtag_dataOut = jtag_data_q;

`ifdef PINGPONG_FILL_COUNT_EN
  logic [AddrWidth:0] hw_q [2];

  // High-water tracking; a clear of the JTAG bank loses to a same-cycle write
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      hw_q[0] <= '0;
      hw_q[1] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (bus.jtag_clear && (1'(b) == jtag_bank)) begin
          hw_q[b] <= wr_en[b] ? ({1'b0, wr_addr[b]} + (AddrWidth+1)'(1)) : '0;
        end else if (wr_en[b] &&
                     (({1'b0, wr_addr[b]} + (AddrWidth+1)'(1)) > hw_q[b])) begin
          hw_q[b] <= {1'b0, wr_addr[b]} + (AddrWidth+1)'(1);
        end
      end
    end
  end

  assign bus.jtag_fill = hw_q[jtag_bank];
  assign bus.dma_fill  = hw_q[bank_select_q];
`else
  localparam logic [AddrWidth:0] FullCount = {1'b1, {AddrWidth{1'b0}}};
  logic unused_jtag_clear;

  assign unused_jtag_clear = bus.jtag_clear;
  assign bus.jtag_fill     = FullCount;
  assign bus.dma_fill      = FullCount;
`endif

endmodule

// File: tb/tb_pingpong_buffer.sv
// tb_pingpong_buffer: directed bench for pingpong_buffer covering reset,
// DMA/JTAG access latency, swap timing, deferred and duplicate requests,
// high-water counters and reset during a swap.
module tb_pingpong_buffer;

  localparam int AW = 9;

  logic clock = 1'b0;
  logic n_reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  pingpong_buffer_if #(.AddrWidth(AW)) bus ();

  pingpong_buffer #(.AddrWidth(AW)) dut (
    .clock   (clock),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Expected fill value: real count with counters built, full bank otherwise
  function automatic logic [AW:0] fill_exp(input int v);
`ifdef PINGPONG_FILL_COUNT_EN
    return (AW+1)'(v);
`else
    return (AW+1)'(1 << AW);
`endif
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.bank_select !== 1'b0) begin errors++; $display("FAIL reset_bank_select got=%0h exp=0", bus.bank_select); end
    checks++; if (bus.swap_pending !== 1'b0) begin errors++; $display("FAIL reset_swap_pending got=%0h exp=0", bus.swap_pending); end
    checks++; if (bus.swap_done !== 1'b0) begin errors++; $display("FAIL reset_swap_done got=%0h exp=0", bus.swap_done); end
    checks++; if (bus.jtag_dataOut !== 32'h0) begin errors++; $display("FAIL reset_jtag_dataOut got=%0h exp=0", bus.jtag_dataOut); end
    checks++; if (bus.jtag_fill !== fill_exp(0)) begin errors++; $display("FAIL reset_jtag_fill got=%0d exp=%0d", bus.jtag_fill, fill_exp(0)); end
    checks++; if (bus.dma_fill !== fill_exp(0)) begin errors++; $display("FAIL reset_dma_fill got=%0d exp=%0d", bus.dma_fill, fill_exp(0)); end
    step();
    n_reset = 1'b1;
    step();
  endtask

  task automatic test_dma_write();
    // Seed the JTAG bank (bank 1) at address 3
    bus.jtag_writeEnable = 1'b1; bus.jtag_address = 9'd3; bus.jtag_dataIn = 32'hB1B1_0003;
    step();
    bus.jtag_writeEnable = 1'b0;
    // DMA write to bank 0 at address 3
    bus.pp_writeEnable = 1'b1; bus.pp_address = 9'd3; bus.pp_dataIn = 32'hA5A5_0001;
    step();
    bus.pp_writeEnable = 1'b0;
    checks++; if (bus.pp_dataOut !== 32'hA5A5_0001) begin errors++; $display("FAIL dma_readback got=%0h exp=a5a50001", bus.pp_dataOut); end
    checks++; if (bus.dma_fill !== fill_exp(4)) begin errors++; $display("FAIL dma_fill_a3 got=%0d exp=%0d", bus.dma_fill, fill_exp(4)); end
    checks++; if (bus.jtag_fill !== fill_exp(4)) begin errors++; $display("FAIL jtag_fill_a3 got=%0d exp=%0d", bus.jtag_fill, fill_exp(4)); end
    // JTAG read of address 3 sees bank 1, not the DMA word
    step();
    checks++; if (bus.jtag_dataOut !== 32'hB1B1_0003) begin errors++; $display("FAIL jtag_read_bank1 got=%0h exp=b1b10003", bus.jtag_dataOut); end
    // Read with same-cycle write returns the old word, new word next cycle
    bus.jtag_writeEnable = 1'b1; bus.jtag_dataIn = 32'hC0DE_0003;
    step();
    bus.jtag_writeEnable = 1'b0;
    checks++; if (bus.jtag_dataOut !== 32'hB1B1_0003) begin errors++; $display("FAIL jtag_read_during_write got=%0h exp=b1b10003", bus.jtag_dataOut); end
    step();
    checks++; if (bus.jtag_dataOut !== 32'hC0DE_0003) begin errors++; $display("FAIL jtag_read_after_write got=%0h exp=c0de0003", bus.jtag_dataOut); end
  endtask

  task automatic test_swap();
    for (int i = 0; i < 8; i++) begin
      bus.jtag_writeEnable = 1'b1; bus.jtag_address = AW'(i); bus.jtag_dataIn = 32'h5000_0000 + i;
      step();
    end
    bus.jtag_writeEnable = 1'b0;
    checks++; if (bus.jtag_fill !== fill_exp(8)) begin errors++; $display("FAIL jtag_fill_8 got=%0d exp=%0d", bus.jtag_fill, fill_exp(8)); end
    bus.swap_request = 1'b1; bus.dma_busy = 1'b0;
    step();
    bus.swap_request = 1'b0;
    checks++; if (bus.swap_pending !== 1'b1) begin errors++; $display("FAIL swap_pending_c1 got=%0h exp=1", bus.swap_pending); end
    checks++; if (bus.swap_done !== 1'b0 || bus.bank_select !== 1'b0) begin errors++; $display("FAIL swap_early_c1 got=done%0h/bank%0h exp=done0/bank0", bus.swap_done, bus.bank_select); end
    step();
    checks++; if (bus.swap_done !== 1'b0 || bus.bank_select !== 1'b0) begin errors++; $display("FAIL swap_early_c2 got=done%0h/bank%0h exp=done0/bank0", bus.swap_done, bus.bank_select); end
    step();
    checks++; if (bus.swap_done !== 1'b1) begin errors++; $display("FAIL swap_done_c3 got=%0h exp=1", bus.swap_done); end
    checks++; if (bus.bank_select !== 1'b1) begin errors++; $display("FAIL swap_bank_c3 got=%0h exp=1", bus.bank_select); end
    checks++; if (bus.swap_pending !== 1'b0) begin errors++; $display("FAIL swap_pending_c3 got=%0h exp=0", bus.swap_pending); end
    checks++; if (bus.dma_fill !== fill_exp(8)) begin errors++; $display("FAIL swap_dma_fill got=%0d exp=%0d", bus.dma_fill, fill_exp(8)); end
    checks++; if (bus.jtag_fill !== fill_exp(4)) begin errors++; $display("FAIL swap_jtag_fill got=%0d exp=%0d", bus.jtag_fill, fill_exp(4)); end
    bus.pp_address = 9'd5;
    #1;
    checks++; if (bus.pp_dataOut !== 32'h5000_0005) begin errors++; $display("FAIL swap_pp_data5 got=%0h exp=50000005", bus.pp_dataOut); end
    step();
    checks++; if (bus.swap_done !== 1'b0) begin errors++; $display("FAIL swap_done_one_cycle got=%0h exp=0", bus.swap_done); end
  endtask

  task automatic test_busy_defer();
    bus.dma_busy = 1'b1; bus.swap_request = 1'b1;
    step();
    bus.swap_request = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (bus.swap_pending !== 1'b1 || bus.bank_select !== 1'b1) begin errors++; $display("FAIL busy_hold_%0d got=pend%0h/bank%0h exp=pend1/bank1", i, bus.swap_pending, bus.bank_select); end
      step();
    end
    bus.dma_busy = 1'b0;
    step();
    checks++; if (bus.swap_pending !== 1'b1 || bus.bank_select !== 1'b1) begin errors++; $display("FAIL busy_release_swap got=pend%0h/bank%0h exp=pend1/bank1", bus.swap_pending, bus.bank_select); end
    step();
    checks++; if (bus.bank_select !== 1'b0 || bus.swap_done !== 1'b1) begin errors++; $display("FAIL busy_release_toggle got=bank%0h/done%0h exp=bank0/done1", bus.bank_select, bus.swap_done); end
  endtask

  task automatic test_double_request();
    int   toggles;
    int   dones;
    logic prev;
    bus.swap_request = 1'b1; bus.dma_busy = 1'b1;
    step();
    step();
    bus.swap_request = 1'b0; bus.dma_busy = 1'b0;
    toggles = 0; dones = 0; prev = bus.bank_select;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.bank_select !== prev) toggles++;
      prev = bus.bank_select;
      if (bus.swap_done === 1'b1) dones++;
    end
    checks++; if (toggles !== 1) begin errors++; $display("FAIL double_req_toggles got=%0d exp=1", toggles); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL double_req_dones got=%0d exp=1", dones); end
    checks++; if (bus.bank_select !== 1'b1 || bus.swap_pending !== 1'b0) begin errors++; $display("FAIL double_req_final got=bank%0h/pend%0h exp=bank1/pend0", bus.bank_select, bus.swap_pending); end
  endtask

  task automatic test_fill();
    // bank_select=1: JTAG owns bank 0, which holds a fill of 4
    bus.jtag_writeEnable = 1'b1; bus.jtag_address = 9'd9; bus.jtag_dataIn = 32'h0;
    step();
    checks++; if (bus.jtag_fill !== fill_exp(10)) begin errors++; $display("FAIL fill_a9 got=%0d exp=%0d", bus.jtag_fill, fill_exp(10)); end
    bus.jtag_clear = 1'b1; bus.jtag_address = 9'd4;
    step();
    checks++; if (bus.jtag_fill !== fill_exp(5)) begin errors++; $display("FAIL fill_clear_write4 got=%0d exp=%0d", bus.jtag_fill, fill_exp(5)); end
    checks++; if (bus.dma_fill !== fill_exp(8)) begin errors++; $display("FAIL fill_dma_untouched got=%0d exp=%0d", bus.dma_fill, fill_exp(8)); end
    bus.jtag_writeEnable = 1'b0;
    step();
    bus.jtag_clear = 1'b0;
    checks++; if (bus.jtag_fill !== fill_exp(0)) begin errors++; $display("FAIL fill_clear_only got=%0d exp=%0d", bus.jtag_fill, fill_exp(0)); end
    bus.jtag_writeEnable = 1'b1; bus.jtag_address = 9'd511;
    step();
    checks++; if (bus.jtag_fill !== fill_exp(512)) begin errors++; $display("FAIL fill_full got=%0d exp=%0d", bus.jtag_fill, fill_exp(512)); end
    bus.jtag_address = 9'd2;
    step();
    bus.jtag_writeEnable = 1'b0;
    checks++; if (bus.jtag_fill !== fill_exp(512)) begin errors++; $display("FAIL fill_no_decrease got=%0d exp=%0d", bus.jtag_fill, fill_exp(512)); end
  endtask

  task automatic test_reset_mid_swap();
    bus.swap_request = 1'b1; bus.dma_busy = 1'b0;
    step();
    bus.swap_request = 1'b0;
    step();
    checks++; if (bus.swap_pending !== 1'b1 || bus.bank_select !== 1'b1) begin errors++; $display("FAIL midswap_pre got=pend%0h/bank%0h exp=pend1/bank1", bus.swap_pending, bus.bank_select); end
    #2;
    n_reset = 1'b0;
    #1;
    checks++; if (bus.bank_select !== 1'b0) begin errors++; $display("FAIL midswap_bank got=%0h exp=0", bus.bank_select); end
    checks++; if (bus.swap_done !== 1'b0 || bus.swap_pending !== 1'b0) begin errors++; $display("FAIL midswap_flags got=done%0h/pend%0h exp=done0/pend0", bus.swap_done, bus.swap_pending); end
    checks++; if (bus.jtag_fill !== fill_exp(0) || bus.dma_fill !== fill_exp(0)) begin errors++; $display("FAIL midswap_fills got=%0d/%0d exp=%0d", bus.jtag_fill, bus.dma_fill, fill_exp(0)); end
    checks++; if (bus.jtag_dataOut !== 32'h0) begin errors++; $display("FAIL midswap_jtag_data got=%0h exp=0", bus.jtag_dataOut); end
    step();
    n_reset = 1'b1;
    step();
    checks++; if (bus.swap_done !== 1'b0 || bus.bank_select !== 1'b0) begin errors++; $display("FAIL midswap_after got=done%0h/bank%0h exp=done0/bank0", bus.swap_done, bus.bank_select); end
  endtask

  initial begin
    bus.pp_address = '0;   bus.pp_dataIn = '0;   bus.pp_writeEnable = 1'b0;
    bus.jtag_address = '0; bus.jtag_dataIn = '0; bus.jtag_writeEnable = 1'b0;
    bus.swap_request = 1'b0; bus.dma_busy = 1'b0; bus.jtag_clear = 1'b0;
    test_reset();
    test_dma_write();
    test_swap();
    test_busy_defer();
    test_double_request();
    test_fill();
    test_reset_mid_swap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
